// File: rtl/spi_flash_rdid_responder_pkg.sv
// Shared constants for the SPI flash ID responder.
// Opcodes, FSM encoding and default ID bytes.
package spi_flash_pkg;

  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam logic [7:0] DEF_MFG_ID   = 8'h20;
  localparam logic [7:0] DEF_MEM_TYPE = 8'h20;
  localparam logic [7:0] DEF_MEM_CAP  = 8'h16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_RESP   = 3'd2,
    ST_IGNORE = 3'd3,
    ST_STAT   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_flash_rdid_responder_if.sv
// SPI bus between master and flash target.
// SPICLK/SPIMOSI/chip_select from master, SPIMISO back.
interface spi_flash_rdid_responder_if;
  logic SPICLK;
  logic SPIMOSI;
  logic chip_select;
  logic SPIMISO;

  modport master (
    output SPICLK,
    output SPIMOSI,
    output chip_select,
    input  SPIMISO
  );

  modport slave (
    input  SPICLK,
    input  SPIMOSI,
    input  chip_select,
    output SPIMISO
  );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with rise/fall pulses.
// Ports: clk, reset_n, d in; sync, rise, fall out.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] q;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      q    <= {q[STAGES-2:0], d};
      prev <= q[STAGES-1];
    end
  end

  assign sync = q[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_flash_rdid_responder.sv
// SPI mode-0 flash ID responder (RDID, optional RDSR).
// Ports: clk, reset_n, spi (slave), cmd_valid, cmd_byte,
// busy; status_byte when SPI_RESP_RDSR_EN is defined.
module spi_flash_rdid_responder
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] MFG_ID      = DEF_MFG_ID,
  parameter logic [7:0] MEM_TYPE    = DEF_MEM_TYPE,
  parameter logic [7:0] MEM_CAP     = DEF_MEM_CAP,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  spi_flash_rdid_responder_if.slave spi,
`ifdef SPI_RESP_RDSR_EN
  input  logic [7:0] status_byte,
`endif
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       busy
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] CMD    = ST_CMD;
  localparam logic [2:0] RESP   = ST_RESP;
  localparam logic [2:0] IGNORE = ST_IGNORE;
`ifdef SPI_RESP_RDSR_EN
  localparam logic [2:0] STAT   = ST_STAT;
`endif

  localparam logic [23:0] ID_WORD =
    {MFG_ID, MEM_TYPE, MEM_CAP};

  logic sclk_s;
  logic sclk_rise;
  logic sclk_fall;

  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic                   mosi_s;
  logic                   cs_s;

  logic [2:0]  state;
  logic [4:0]  bit_cnt;
  logic [7:0]  opcode_sr;
  logic [23:0] resp_sr;
  logic [7:0]  op_next;
  logic        miso;
`ifdef SPI_RESP_RDSR_EN
  logic [7:0]  stat_sr;
`endif

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (spi.SPICLK),
    .sync    (sclk_s),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_q <= '0;
      cs_q   <= '1;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.SPIMOSI};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi.chip_select};
    end
  end

  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign busy    = ~cs_s;
  assign op_next = {opcode_sr[6:0], mosi_s};
  assign spi.SPIMISO = miso;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      opcode_sr <= '0;
      resp_sr   <= '0;
      miso      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
`ifdef SPI_RESP_RDSR_EN
      stat_sr   <= '0;
`endif
    end else begin
      cmd_valid <= 1'b0;
      // Deselect overrides any SPICLK edge in the same clk.
      if (cs_s) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        opcode_sr <= '0;
        miso      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state     <= CMD;
            bit_cnt   <= '0;
            opcode_sr <= '0;
            miso      <= 1'b0;
          end
          CMD: begin
            if (sclk_rise) begin
              opcode_sr <= op_next;
              bit_cnt   <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                cmd_byte  <= op_next;
                cmd_valid <= 1'b1;
                bit_cnt   <= '0;
                unique case (1'b1)
                  (op_next == OP_RDID): begin
                    state   <= RESP;
                    resp_sr <= ID_WORD;
                  end
`ifdef SPI_RESP_RDSR_EN
                  (op_next == OP_RDSR): begin
                    state <= STAT;
                  end
`endif
                  default: state <= IGNORE;
                endcase
              end
            end
          end
          RESP: begin
            if (sclk_fall) begin
              miso <= resp_sr[23];
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                resp_sr <= ID_WORD;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                resp_sr <= {resp_sr[22:0], 1'b0};
              end
            end
          end
          IGNORE: begin
            miso <= 1'b0;
          end
`ifdef SPI_RESP_RDSR_EN
          STAT: begin
            if (sclk_fall) begin
              // Fresh status sampled at each byte start.
              if (bit_cnt == 5'd0) begin
                miso    <= status_byte[7];
                stat_sr <= {status_byte[6:0], 1'b0};
              end else begin
                miso    <= stat_sr[7];
                stat_sr <= {stat_sr[6:0], 1'b0};
              end
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`endif
          default: begin
            state <= IDLE;
            miso  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_rdid_responder.sv
// Directed bench for spi_flash_rdid_responder.
// Drives an SPI mode-0 master at clk = 10x SPICLK.
module tb_spi_flash_rdid_responder;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       busy;
`ifdef SPI_RESP_RDSR_EN
  logic [7:0] status_byte;
`endif

  int checks;
  int errors;
  int valid_cnt;

  logic [47:0] rd;

  spi_flash_rdid_responder_if bus ();

  spi_flash_rdid_responder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi         (bus.slave),
`ifdef SPI_RESP_RDSR_EN
    .status_byte (status_byte),
`endif
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(
    input string       tag,
    input logic [47:0] obs,
    input logic [47:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.chip_select = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_high();
    wait_clk(5);
    bus.chip_select = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bits(
    input logic [7:0] op,
    input int         n
  );
    for (int i = 0; i < n; i++) begin
      bus.SPIMOSI = op[7-i];
      wait_clk(5);
      bus.SPICLK = 1'b1;
      wait_clk(5);
      bus.SPICLK = 1'b0;
    end
    bus.SPIMOSI = 1'b0;
  endtask

  task automatic read_bits(
    input  int          n,
    output logic [47:0] d
  );
    d = '0;
    for (int i = 0; i < n; i++) begin
      wait_clk(5);
      d = {d[46:0], bus.SPIMISO};
      bus.SPICLK = 1'b1;
      wait_clk(5);
      bus.SPICLK = 1'b0;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    valid_cnt = 0;
    reset_n   = 1'b0;
    bus.SPICLK      = 1'b0;
    bus.SPIMOSI     = 1'b0;
    bus.chip_select = 1'b1;
`ifdef SPI_RESP_RDSR_EN
    status_byte = 8'hA5;
`endif
    wait_clk(3);
    check("rst_miso", 48'(bus.SPIMISO), 48'h0);
    check("rst_valid", 48'(cmd_valid), 48'h0);
    check("rst_byte", 48'(cmd_byte), 48'h00);
    check("rst_busy", 48'(busy), 48'h0);
    reset_n = 1'b1;
    wait_clk(5);

    // SPICLK toggling while deselected
    for (int i = 0; i < 8; i++) begin
      bus.SPICLK = ~bus.SPICLK;
      wait_clk(5);
    end
    bus.SPICLK = 1'b0;
    wait_clk(5);
    check("quiet_valid", 48'(valid_cnt), 48'd0);
    check("quiet_busy", 48'(busy), 48'h0);

    // 1: basic RDID
    cs_low();
    check("busy_hi", 48'(busy), 48'h1);
    send_bits(8'h9F, 8);
    read_bits(24, rd);
    cs_high();
    check("rdid", rd, 48'h202016);
    check("rdid_byte", 48'(cmd_byte), 48'h9F);
    check("rdid_vcnt", 48'(valid_cnt), 48'd1);
    check("busy_lo", 48'(busy), 48'h0);

    // 2: continued read wraps
    cs_low();
    send_bits(8'h9F, 8);
    read_bits(48, rd);
    cs_high();
    check("wrap", rd, 48'h202016202016);
    check("wrap_vcnt", 48'(valid_cnt), 48'd2);

    // 3: unknown opcode then RDID
    cs_low();
    send_bits(8'h03, 8);
    read_bits(16, rd);
    cs_high();
    check("unk_miso", rd, 48'h0);
    check("unk_byte", 48'(cmd_byte), 48'h03);
    check("unk_vcnt", 48'(valid_cnt), 48'd3);
    cs_low();
    send_bits(8'h9F, 8);
    read_bits(24, rd);
    cs_high();
    check("post_unk", rd, 48'h202016);
    check("post_vcnt", 48'(valid_cnt), 48'd4);

    // 4: abort mid-opcode, then mid-data
    cs_low();
    send_bits(8'h03, 5);
    cs_high();
    check("abort_op_vcnt", 48'(valid_cnt), 48'd4);
    check("abort_op_byte", 48'(cmd_byte), 48'h9F);
    cs_low();
    send_bits(8'h9F, 8);
    read_bits(10, rd);
    cs_high();
    check("abort_dat", rd, 48'h080);
    cs_low();
    send_bits(8'h9F, 8);
    read_bits(24, rd);
    cs_high();
    check("post_abort", rd, 48'h202016);
    check("abort_vcnt", 48'(valid_cnt), 48'd6);

    // 5: async reset mid-response
    cs_low();
    send_bits(8'h9F, 8);
    read_bits(6, rd);
    wait_clk(3);
    reset_n = 1'b0;
    #1;
    check("arst_miso", 48'(bus.SPIMISO), 48'h0);
    check("arst_busy", 48'(busy), 48'h0);
    check("arst_byte", 48'(cmd_byte), 48'h00);
    check("arst_valid", 48'(cmd_valid), 48'h0);
    @(negedge clk);
    bus.chip_select = 1'b1;
    bus.SPICLK      = 1'b0;
    reset_n         = 1'b1;
    wait_clk(10);
    cs_low();
    send_bits(8'h9F, 8);
    read_bits(24, rd);
    cs_high();
    check("post_rst", rd, 48'h202016);
    check("post_rst_byte", 48'(cmd_byte), 48'h9F);
    check("post_rst_vcnt", 48'(valid_cnt), 48'd8);

`ifdef SPI_RESP_RDSR_EN
    // 6: RDSR with live status
    status_byte = 8'hA5;
    cs_low();
    send_bits(8'h05, 8);
    read_bits(16, rd);
    cs_high();
    check("rdsr_rep", rd, 48'hA5A5);
    check("rdsr_byte", 48'(cmd_byte), 48'h05);
    cs_low();
    send_bits(8'h05, 8);
    read_bits(8, rd);
    status_byte = 8'h01;
    check("rdsr_1st", rd, 48'hA5);
    read_bits(8, rd);
    cs_high();
    check("rdsr_2nd", rd, 48'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_rdid_responder.md
Name: spi_flash_rdid_responder

Overview:
- SPI mode-0 target that emulates the identification path of a serial flash device.
- Acts as the bench and board stand-in for the flash device that our SPI master queries.
- Oversamples SPICLK, SPIMOSI and chip_select on the system clock, decodes an 8-bit opcode, and answers RDID (0x9F) by shifting out three ID bytes MSB-first on SPIMISO.
- Other opcodes are ignored until the next chip_select deassertion.

Parameters:
- MFG_ID, 8'h20, manufacturer ID byte. Sent first.
- MEM_TYPE, 8'h20, memory type byte. Sent second.
- MEM_CAP, 8'h16, memory capacity byte. Sent third.
- SYNC_STAGES, 2, synchronizer depth on SPICLK, SPIMOSI and chip_select. Legal range is 2 to 3.

Ports:
- clk  in  1  system clock. Must run at 8x or more the SPICLK frequency.
- reset_n  in  1  asynchronous active-low reset.
- SPICLK  in  1  SPI clock from the master. Idles low (mode 0).
- SPIMOSI  in  1  serial data from the master.
- chip_select  in  1  active-low target select.
- SPIMISO  out  1  serial data to the master.
- cmd_valid  out  1  one-clk pulse when an opcode byte completes.
- cmd_byte  out  8  last decoded opcode. Held until the next completed opcode.
- busy  out  1  high while chip_select is low (synchronized).

Behaviour:
- Reset: asynchronous, active-low, applied on reset_n. Reset values:
  - state = IDLE
  - SPIMISO = 0
  - cmd_valid = 0
  - cmd_byte = 8'h00
  - busy = 0
  - bit counter = 0
  - shift registers = 0
  - synchronizer flops = 1 for chip_select, 0 for the others
- Input conditioning: each input passes through SYNC_STAGES flops. Edges are detected on the synchronized SPICLK:
  - rise = sync high while the previous sample was low
  - fall = the opposite
- Input-to-decision latency is SYNC_STAGES+1 clk.
- States:
  - IDLE: waits for synchronized chip_select = 0, then goes to CMD. Bit counter cleared, SPIMISO = 0.
  - CMD: on each rise, shift SPIMOSI into opcode_sr (LSB in, MSB first on the wire) and increment the bit counter. On the 8th rise:
    - cmd_byte <= the assembled byte; cmd_valid pulses on the next clk.
    - Opcode 0x9F: go to RESP and load resp_sr = {MFG_ID, MEM_TYPE, MEM_CAP}.
    - Any other opcode: go to IGNORE.
  - RESP:
    - On each fall, SPIMISO <= resp_sr[23] and resp_sr shifts left by 1.
    - The first fall after the 8th opcode rise drives bit 23, so the bit is stable before the master samples on the next rise.
    - After 24 bits are driven, resp_sr reloads, so a continued read wraps to MFG_ID.
  - IGNORE: SPIMISO = 0 and edges are ignored.
- Chip_select deassertion: synchronized chip_select = 1 in any state forces IDLE on the next clk.
  - The partial opcode is discarded and cmd_valid is not pulsed.
  - SPIMISO = 0.
  - This applies mid-opcode and mid-response alike.
- Simultaneous events: if a chip_select rise and an SPICLK edge land in the same clk, chip_select wins and the edge is dropped.
- Quiet SPICLK: an SPICLK toggle while chip_select is high is ignored.
- reset_n asserted mid-transaction: all outputs return to reset values immediately.

Optional Feature:
- Macro: SPI_RESP_RDSR_EN.
- When defined:
  - Adds input status_byte [7:0].
  - Opcode 0x05 (RDSR) goes to state STAT. STAT shifts status_byte out MSB-first on falls.
  - status_byte is re-captured at the start of each 8-bit repetition, so repeated reads track live status.
- When undefined:
  - No port is added.
  - 0x05 is treated as an unknown opcode and goes to IGNORE.

Decomposition:
- Shared package spi_flash_pkg holds:
  - opcode constants OP_RDID = 8'h9F and OP_RDSR = 8'h05
  - state encoding: IDLE, CMD, RESP, IGNORE, STAT as a 3-bit enum
  - default ID constants
- One sub-module, spi_sync_edge: an N-stage synchronizer with rise/fall pulse outputs. It is instantiated for SPICLK; plain sync only for SPIMOSI and chip_select.

Test Plan:
1. RDID with defaults. Master sends 0x9F, then clocks 24 bits, at clk = 10x SPICLK.
   - Required: cmd_valid pulses once with cmd_byte = 8'h9F.
   - Required: the master captures 24'h202016.
2. Continued read. 0x9F, then 48 data clocks.
   - Required: the second 24 bits again read 24'h202016 (wrap).
3. Unknown opcode. Send 0x03, then 16 clocks.
   - Required: cmd_byte = 8'h03 and SPIMISO stays 0 for all 16 bits.
   - Then send 0x9F in a new frame; required: 24'h202016.
4. Abort mid-opcode and mid-data.
   - Raise chip_select after 5 opcode bits; required: no cmd_valid.
   - Raise chip_select after 10 response bits, then issue a fresh RDID; required: a full 24'h202016 with no stale bits.
5. Async reset. Drop reset_n for 1 clk in the middle of RESP.
   - Required: SPIMISO = 0, busy = 0 and cmd_byte = 8'h00 within the same cycle.
   - Required: the next frame works normally.
6. With SPI_RESP_RDSR_EN defined and status_byte = 8'hA5, send 0x05 and 16 clocks.
   - Required: the master reads 8'hA5 twice.
   - Change status_byte to 8'h01 between repetitions; required: the second byte reads 8'h01.
